// File: rtl/gamepad_serial_rx_pkg.sv
// Shared types and constants for the SNES-style gamepad serial receiver.
// Button bit indices refer to the captured word: oldest bit at the MSB, newest at the LSB.
package gamepad_serial_rx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int          FRAME_W      = 12;
    localparam logic [11:0] DISCONNECTED = 12'hFFF;
    localparam logic [4:0]  BITCNT_MAX   = 5'd31;

    localparam int BIT_B      = 11;
    localparam int BIT_Y      = 10;
    localparam int BIT_SELECT = 9;
    localparam int BIT_START  = 8;
    localparam int BIT_UP     = 7;
    localparam int BIT_DOWN   = 6;
    localparam int BIT_LEFT   = 5;
    localparam int BIT_RIGHT  = 4;
    localparam int BIT_A      = 3;
    localparam int BIT_X      = 2;
    localparam int BIT_L      = 1;
    localparam int BIT_R      = 0;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == BITCNT_MAX) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/gamepad_serial_rx_if.sv
// Pad-side serial lines plus the decoded button/status outputs of the receiver.
// master = pad/stimulus side, slave = receiver side.
interface gamepad_serial_rx_if;
    logic pmod_data;
    logic pmod_clk;
    logic pmod_latch;
    logic b, y, select, start, up, down, left, right, a, x, l, r;
    logic present;
    logic frame_strobe;

    modport master (
        output pmod_data, pmod_clk, pmod_latch,
        input  b, y, select, start, up, down, left, right, a, x, l, r,
        input  present, frame_strobe
    );

    modport slave (
        input  pmod_data, pmod_clk, pmod_latch,
        output b, y, select, start, up, down, left, right, a, x, l, r,
        output present, frame_strobe
    );
endinterface

// File: rtl/gamepad_sync_edge.sv
// Multi-flop synchroniser with registered rising-edge pulse; STAGES must be >= 2.
// Latency: sync_out after STAGES clocks, rise one clock later; no backpressure.
module gamepad_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_dly;
    logic              r_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
            r_dly  <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_dly;
        end
    end

    assign sync_out = r_sync[STAGES-1];
    assign rise     = r_rise;
endmodule

// File: rtl/gamepad_serial_rx.sv
// Receives a 12-bit gamepad frame on pmod_clk, captures it on pmod_latch, detects disconnect/timeout.
// Latency: outputs update SYNC_STAGES+2 clocks after the raw latch rise is sampled; no backpressure.
module gamepad_serial_rx
    import gamepad_serial_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    gamepad_serial_rx_if.slave  bus
);
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE = TIMEOUT_W'(1);

    logic w_data_sync, w_data_rise;
    logic w_clk_sync,  w_clk_rise;
    logic w_latch_sync, w_latch_rise;
    logic w_unused_sync;

    gamepad_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .async_in(bus.pmod_data),
        .sync_out(w_data_sync), .rise(w_data_rise)
    );
    gamepad_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .async_in(bus.pmod_clk),
        .sync_out(w_clk_sync), .rise(w_clk_rise)
    );
    gamepad_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latch (
        .clk(clk), .rst_n(rst_n), .async_in(bus.pmod_latch),
        .sync_out(w_latch_sync), .rise(w_latch_rise)
    );

    assign w_unused_sync = ^{w_data_rise, w_clk_sync, w_latch_sync};

    state_e               r_state, w_state_nxt;
    logic [FRAME_W-1:0]   r_shift;
    logic [4:0]           r_bitcnt;
    logic [TIMEOUT_W-1:0] r_wdog, w_wdog_nxt;
    logic [FRAME_W-1:0]   r_buttons;
    logic                 r_present;
    logic                 r_strobe;
    logic                 w_wdog_hit;
    logic                 w_capture_ok;

    // The timeout fires once, on the edge the counter reaches its maximum; saturation then keeps it quiet.
    always_comb begin
        w_wdog_nxt = r_wdog;
        if (w_latch_rise) begin
            w_wdog_nxt = '0;
        end else if (r_wdog != WDOG_MAX) begin
            w_wdog_nxt = r_wdog + WDOG_ONE;
        end
        w_wdog_hit   = (r_wdog != WDOG_MAX) && (w_wdog_nxt == WDOG_MAX);
        w_capture_ok = (r_bitcnt >= 5'(FRAME_W));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_clk_rise && !w_latch_rise) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_latch_rise || w_wdog_hit)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_wdog    <= '0;
            r_buttons <= '0;
            r_present <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wdog   <= w_wdog_nxt;
            r_strobe <= 1'b0;
            if (w_latch_rise) begin
                // A pmod_clk edge coinciding with the latch is dropped on purpose.
                r_shift  <= '0;
                r_bitcnt <= '0;
                if (w_capture_ok) begin
                    r_strobe <= 1'b1;
                    if (r_shift == DISCONNECTED) begin
                        r_buttons <= '0;
                        r_present <= 1'b0;
                    end else begin
                        r_buttons <= r_shift;
                        r_present <= 1'b1;
                    end
                end else begin
                    r_present <= 1'b0;
                end
            end else begin
                if (w_clk_rise) begin
                    r_shift  <= {r_shift[FRAME_W-2:0], w_data_sync};
                    r_bitcnt <= sat_inc5(r_bitcnt);
                end
                if (w_wdog_hit) begin
                    r_buttons <= '0;
                    r_present <= 1'b0;
                end
            end
        end
    end

    assign bus.b            = r_buttons[BIT_B];
    assign bus.y            = r_buttons[BIT_Y];
    assign bus.select       = r_buttons[BIT_SELECT];
    assign bus.start        = r_buttons[BIT_START];
    assign bus.up           = r_buttons[BIT_UP];
    assign bus.down         = r_buttons[BIT_DOWN];
    assign bus.left         = r_buttons[BIT_LEFT];
    assign bus.right        = r_buttons[BIT_RIGHT];
    assign bus.a            = r_buttons[BIT_A];
    assign bus.x            = r_buttons[BIT_X];
    assign bus.l            = r_buttons[BIT_L];
    assign bus.r            = r_buttons[BIT_R];
    assign bus.present      = r_present;
    assign bus.frame_strobe = r_strobe;
endmodule

// File: tb/tb_gamepad_serial_rx.sv
// Bench for gamepad_serial_rx: directed vector table, multi-cycle corner sequences and a
// randomized frame stream checked against a queue-based model of the frame rules.
module tb_gamepad_serial_rx;
    import gamepad_serial_rx_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    gamepad_serial_rx_if bus ();

    gamepad_serial_rx #(.SYNC_STAGES(2), .TIMEOUT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // Reference model: bits received since the last latch, plus the last reported outputs.
    bit          mq[$];
    logic [11:0] m_btn;
    logic        m_present;

    task automatic model_reset();
        mq.delete();
        m_btn     = '0;
        m_present = 1'b0;
    endtask

    task automatic model_latch(output logic [11:0] eb, output logic ep, output logic es);
        logic [11:0] w;
        w  = '0;
        es = 1'b0;
        if (mq.size() >= 12) begin
            for (int i = mq.size() - 12; i < mq.size(); i++) w = {w[10:0], mq[i]};
            es = 1'b1;
            if (w == 12'hFFF) begin
                m_btn     = '0;
                m_present = 1'b0;
            end else begin
                m_btn     = w;
                m_present = 1'b1;
            end
        end else begin
            m_present = 1'b0;
        end
        mq.delete();
        eb = m_btn;
        ep = m_present;
    endtask

    function automatic logic [11:0] got_btn();
        return {bus.b, bus.y, bus.select, bus.start, bus.up, bus.down,
                bus.left, bus.right, bus.a, bus.x, bus.l, bus.r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic send_bit(input logic d);
        @(negedge clk);
        bus.pmod_data = d;
        bus.pmod_clk  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.pmod_clk  = 1'b1;
        mq.push_back(d);
        @(negedge clk);
    endtask

    task automatic send_frame(input int nbits, input logic [23:0] bits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    // Raises latch (optionally with pmod_clk in the same cycle) and checks strobe count,
    // strobe latency in clocks counted from the first sampling edge, buttons and present.
    task automatic do_latch(input logic with_clk, input logic [11:0] eb, input logic ep,
                            input logic es, input string nm);
        int first_k = 0;
        int nstb    = 0;
        @(negedge clk);
        bus.pmod_clk   = 1'b0;
        @(negedge clk);
        bus.pmod_latch = 1'b1;
        if (with_clk) begin
            bus.pmod_data = 1'b1;
            bus.pmod_clk  = 1'b1;
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (bus.frame_strobe) begin
                nstb++;
                if (first_k == 0) first_k = k;
            end
        end
        @(negedge clk);
        bus.pmod_latch = 1'b0;
        bus.pmod_clk   = 1'b0;
        chk({nm, "_strobes"}, nstb, {31'b0, es});
        if (es) chk({nm, "_latency"}, first_k, 4);
        chk({nm, "_buttons"}, {20'b0, got_btn()}, {20'b0, eb});
        chk({nm, "_present"}, {31'b0, bus.present}, {31'b0, ep});
    endtask

    typedef struct {
        int          nbits;
        logic [23:0] bits;
        logic [11:0] eb;
        logic        ep;
        logic        es;
    } vec_t;

    vec_t        tbl[8];
    logic [11:0] eb;
    logic        ep, es;
    bit          seen;

    initial begin
        tbl[0] = '{12, 24'h000801, 12'h801, 1'b1, 1'b1};
        tbl[1] = '{24, 24'hFFF080, 12'h080, 1'b1, 1'b1};
        tbl[2] = '{12, 24'h000FFF, 12'h000, 1'b0, 1'b1};
        tbl[3] = '{12, 24'h000A5C, 12'hA5C, 1'b1, 1'b1};
        tbl[4] = '{7,  24'h000055, 12'hA5C, 1'b0, 1'b0};
        tbl[5] = '{12, 24'h0003C3, 12'h3C3, 1'b1, 1'b1};
        tbl[6] = '{0,  24'h000000, 12'h3C3, 1'b0, 1'b0};
        tbl[7] = '{13, 24'h001555, 12'h555, 1'b1, 1'b1};

        bus.pmod_data  = 1'b0;
        bus.pmod_clk   = 1'b0;
        bus.pmod_latch = 1'b0;
        rst_n          = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_buttons", {20'b0, got_btn()}, 32'h0);
        chk("reset_present", {31'b0, bus.present}, 32'h0);
        chk("reset_strobe",  {31'b0, bus.frame_strobe}, 32'h0);
        chk("reset_state",   32'(dut.r_state), 32'(ST_IDLE));

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].nbits, tbl[i].bits);
            model_latch(eb, ep, es);
            do_latch(1'b0, tbl[i].eb, tbl[i].ep, tbl[i].es, $sformatf("vec%0d", i));
        end

        // pmod_clk and latch rising together: the clock edge must not shift in.
        send_frame(12, 24'h0006A9);
        model_latch(eb, ep, es);
        do_latch(1'b1, 12'h6A9, 1'b1, 1'b1, "same_cycle");
        send_frame(11, 24'h0007FE);
        model_latch(eb, ep, es);
        do_latch(1'b0, 12'h6A9, 1'b0, 1'b0, "same_cycle_cnt");

        // Reset in the middle of a frame discards partial bits.
        send_frame(12, 24'h000123);
        model_latch(eb, ep, es);
        do_latch(1'b0, 12'h123, 1'b1, 1'b1, "pre_reset");
        send_frame(5, 24'h00001F);
        @(negedge clk);
        bus.pmod_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("midreset_buttons", {20'b0, got_btn()}, 32'h0);
        chk("midreset_present", {31'b0, bus.present}, 32'h0);
        send_frame(7, 24'h00007F);
        model_latch(eb, ep, es);
        do_latch(1'b0, 12'h000, 1'b0, 1'b0, "postreset_short");
        send_frame(12, 24'h000C35);
        model_latch(eb, ep, es);
        do_latch(1'b0, 12'hC35, 1'b1, 1'b1, "postreset_full");

        // Watchdog: 63 clocks with no latch after a valid capture clears the outputs.
        send_frame(12, 24'h0000F0);
        model_latch(eb, ep, es);
        @(negedge clk);
        bus.pmod_clk   = 1'b0;
        @(negedge clk);
        bus.pmod_latch = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.frame_strobe) seen = 1'b1;
        end
        chk("wdog_strobe_seen", {31'b0, seen}, 32'h1);
        for (int n = 1; n <= 63; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) bus.pmod_latch = 1'b0;
            if (n == 3) bus.pmod_data  = 1'b1;
            if (n == 5) begin
                bus.pmod_clk = 1'b1;
                mq.push_back(1'b1);
            end
            if (n == 9) bus.pmod_clk = 1'b0;
            if (n == 20) chk("wdog_state_shift", 32'(dut.r_state), 32'(ST_SHIFT));
            if (n == 62) begin
                chk("wdog62_buttons", {20'b0, got_btn()}, 32'h0F0);
                chk("wdog62_present", {31'b0, bus.present}, 32'h1);
            end
            if (n == 63) begin
                chk("wdog63_buttons", {20'b0, got_btn()}, 32'h0);
                chk("wdog63_present", {31'b0, bus.present}, 32'h0);
                chk("wdog63_state",   32'(dut.r_state), 32'(ST_IDLE));
            end
        end
        m_btn     = '0;
        m_present = 1'b0;

        for (int i = 0; i < 25; i++) begin
            int          nb;
            logic [23:0] rb;
            nb = $urandom_range(0, 13);
            rb = 24'($urandom);
            if ($urandom_range(0, 4) == 0) rb = '1;
            send_frame(nb, rb);
            model_latch(eb, ep, es);
            do_latch(1'b0, eb, ep, es, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
